// File: rtl/cond_logic.sv
// Conditional-execution unit: holds the {N,Z,C,V} flag register, evaluates the
// instruction condition field against it and gates the decoder's write enables.
module cond_logic (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  input  logic       Stall,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic [3:0] Flags
);

  logic [3:0] flags_q;
  logic [3:0] flags_d;
  logic       flag_n;
  logic       flag_z;
  logic       flag_c;
  logic       flag_v;
  logic       ge;
  logic       commit;

  assign flag_n = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_c = flags_q[1];
  assign flag_v = flags_q[0];
  assign ge     = (flag_n == flag_v);

  // Condition is judged against the registered flags only, never ALUFlags.
  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      4'b0000: CondEx = flag_z;
      4'b0001: CondEx = ~flag_z;
      4'b0010: CondEx = flag_c;
      4'b0011: CondEx = ~flag_c;
      4'b0100: CondEx = flag_n;
      4'b0101: CondEx = ~flag_n;
      4'b0110: CondEx = flag_v;
      4'b0111: CondEx = ~flag_v;
      4'b1000: CondEx = flag_c & ~flag_z;
      4'b1001: CondEx = ~flag_c | flag_z;
      4'b1010: CondEx = ge;
      4'b1011: CondEx = ~ge;
      4'b1100: CondEx = ~flag_z & ge;
      4'b1101: CondEx = flag_z | ~ge;
      default: CondEx = 1'b1;
    endcase
  end

  assign commit = CondEx & ~Stall & reset_n;

  assign PCSrc    = PCS  & commit;
  assign RegWrite = RegW & commit & ~NoWrite;
  assign MemWrite = MemW & commit;

  // N,Z and C,V are written independently so logical ops can keep C,V.
  always_comb begin
    flags_d = flags_q;
    if (!Stall) begin
      if (FlagW[1] && CondEx) flags_d[3:2] = ALUFlags[3:2];
      if (FlagW[0] && CondEx) flags_d[1:0] = ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) flags_q <= 4'b0000;
    else          flags_q <= flags_d;
  end

  assign Flags = flags_q;

endmodule

// File: tb/tb_cond_logic.sv
// Directed bench for cond_logic: reset, compare/branch, partial flag writes,
// failed conditions, full condition sweep and stall behaviour.
module tb_cond_logic;

  logic       clk;
  logic       reset_n;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;
  logic       Stall;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic       CondEx;
  logic [3:0] Flags;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [3:0] exp_q[$];

  cond_logic dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .RegW     (RegW),
    .MemW     (MemW),
    .NoWrite  (NoWrite),
    .Stall    (Stall),
    .PCSrc    (PCSrc),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .CondEx   (CondEx),
    .Flags    (Flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // 1 unit after that, well clear of the next edge.
  task automatic set_idle();
    Cond = 4'b1110; ALUFlags = 4'b0000; FlagW = 2'b00;
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0; Stall = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_flags(input logic [3:0] f);
    set_idle();
    Cond = 4'b1110; FlagW = 2'b11; ALUFlags = f;
    step();
    set_idle();
  endtask

  // Independent formulation of the condition table, written from the
  // mnemonic meanings rather than the bit encoding.
  function automatic logic exp_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, res;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    res = 1'b1;
    if      (c == 4'd0)  res = z;
    else if (c == 4'd1)  res = !z;
    else if (c == 4'd2)  res = cy;
    else if (c == 4'd3)  res = !cy;
    else if (c == 4'd4)  res = n;
    else if (c == 4'd5)  res = !n;
    else if (c == 4'd6)  res = v;
    else if (c == 4'd7)  res = !v;
    else if (c == 4'd8)  res = cy && !z;
    else if (c == 4'd9)  res = !(cy && !z);
    else if (c == 4'd10) res = !(n ^ v);
    else if (c == 4'd11) res = n ^ v;
    else if (c == 4'd12) res = !z && !(n ^ v);
    else if (c == 4'd13) res = !(!z && !(n ^ v));
    return res;
  endfunction

  task automatic test_reset();
    set_idle();
    reset_n = 1'b0; FlagW = 2'b11; ALUFlags = 4'b1111; RegW = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      total_cnt++;
      if (RegWrite !== 1'b0) $display("FAIL reset_regwrite cyc%0d: got %b want 0", i, RegWrite);
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if (Flags !== 4'b0000) $display("FAIL reset_flags: got %b want 0000", Flags);
    else pass_cnt++;
    reset_n = 1'b1;
    set_idle();
    Cond = 4'b0000; #1;
    total_cnt++;
    if (CondEx !== 1'b0) $display("FAIL reset_eq: got %b want 0", CondEx);
    else pass_cnt++;
    Cond = 4'b0001; #1;
    total_cnt++;
    if (CondEx !== 1'b1) $display("FAIL reset_ne: got %b want 1", CondEx);
    else pass_cnt++;
    step();
  endtask

  task automatic test_cmp_beq();
    set_idle();
    Cond = 4'b1110; FlagW = 2'b11; NoWrite = 1'b1; RegW = 1'b1; ALUFlags = 4'b0110;
    #1;
    total_cnt++;
    if (RegWrite !== 1'b0) $display("FAIL cmp_regwrite: got %b want 0", RegWrite);
    else pass_cnt++;
    step();
    total_cnt++;
    if (Flags !== 4'b0110) $display("FAIL cmp_flags: got %b want 0110", Flags);
    else pass_cnt++;
    set_idle();
    Cond = 4'b0000; PCS = 1'b1; #1;
    total_cnt++;
    if (CondEx !== 1'b1 || PCSrc !== 1'b1)
      $display("FAIL beq_taken: got CondEx=%b PCSrc=%b want 1 1", CondEx, PCSrc);
    else pass_cnt++;
    step();
  endtask

  task automatic test_partial_write();
    load_flags(4'b0011);
    Cond = 4'b1110; FlagW = 2'b10; ALUFlags = 4'b1000;
    step();
    total_cnt++;
    if (Flags !== 4'b1011) $display("FAIL partial_nz: got %b want 1011", Flags);
    else pass_cnt++;
    FlagW = 2'b01; ALUFlags = 4'b0100;
    step();
    total_cnt++;
    if (Flags !== 4'b1000) $display("FAIL partial_cv: got %b want 1000", Flags);
    else pass_cnt++;
    set_idle();
  endtask

  task automatic test_failed_cond();
    load_flags(4'b0000);
    Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b0100; MemW = 1'b1; RegW = 1'b1; PCS = 1'b1;
    #1;
    total_cnt++;
    if (CondEx !== 1'b0 || MemWrite !== 1'b0 || RegWrite !== 1'b0 || PCSrc !== 1'b0)
      $display("FAIL failcond_outs: got CondEx=%b Mem=%b Reg=%b PC=%b want 0 0 0 0",
               CondEx, MemWrite, RegWrite, PCSrc);
    else pass_cnt++;
    step();
    total_cnt++;
    if (Flags !== 4'b0000) $display("FAIL failcond_flags: got %b want 0000", Flags);
    else pass_cnt++;
    set_idle();
  endtask

  task automatic test_cond_sweep();
    logic [3:0] f, c;
    for (int fi = 0; fi < 16; fi++) begin
      f = fi[3:0];
      load_flags(f);
      total_cnt++;
      if (Flags !== f) $display("FAIL sweep_load: got %b want %b", Flags, f);
      else pass_cnt++;
      for (int ci = 0; ci < 16; ci++) begin
        c = ci[3:0];
        Cond = c; #1;
        total_cnt++;
        if (CondEx !== exp_cond(c, f))
          $display("FAIL sweep flags=%b cond=%b: got %b want %b", f, c, CondEx, exp_cond(c, f));
        else pass_cnt++;
      end
    end
    load_flags(4'b1001);
    Cond = 4'b1010; #1;
    total_cnt++;
    if (CondEx !== 1'b1) $display("FAIL sweep_ge_1001: got %b want 1", CondEx);
    else pass_cnt++;
    Cond = 4'b1011; #1;
    total_cnt++;
    if (CondEx !== 1'b0) $display("FAIL sweep_lt_1001: got %b want 0", CondEx);
    else pass_cnt++;
    Cond = 4'b1100; #1;
    total_cnt++;
    if (CondEx !== 1'b1) $display("FAIL sweep_gt_1001: got %b want 1", CondEx);
    else pass_cnt++;
    set_idle();
  endtask

  task automatic test_stall();
    logic [3:0] exp;
    load_flags(4'b0100);
    for (int i = 0; i < 3; i++) exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1010);
    Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1010; RegW = 1'b1; MemW = 1'b1; PCS = 1'b1;
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++;
      if (RegWrite !== 1'b0 || MemWrite !== 1'b0 || PCSrc !== 1'b0)
        $display("FAIL stall_outs cyc%0d: got Reg=%b Mem=%b PC=%b want 0 0 0",
                 i, RegWrite, MemWrite, PCSrc);
      else pass_cnt++;
      step();
      exp = exp_q.pop_front();
      total_cnt++;
      if (Flags !== exp) $display("FAIL stall_flags cyc%0d: got %b want %b", i, Flags, exp);
      else pass_cnt++;
    end
    Stall = 1'b0; #1;
    total_cnt++;
    if (RegWrite !== 1'b1) $display("FAIL stall_release_regwrite: got %b want 1", RegWrite);
    else pass_cnt++;
    step();
    exp = exp_q.pop_front();
    total_cnt++;
    if (Flags !== exp) $display("FAIL stall_release_flags: got %b want %b", Flags, exp);
    else pass_cnt++;
    set_idle();
  endtask

  task automatic test_reset_midseq();
    load_flags(4'b1111);
    Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0101; Stall = 1'b1; RegW = 1'b1;
    reset_n = 1'b0;
    step();
    total_cnt++;
    if (Flags !== 4'b0000) $display("FAIL midreset_flags: got %b want 0000", Flags);
    else pass_cnt++;
    Stall = 1'b0; reset_n = 1'b1;
    step();
    total_cnt++;
    if (Flags !== 4'b0101) $display("FAIL midreset_release: got %b want 0101", Flags);
    else pass_cnt++;
    set_idle();
  endtask

  initial begin
    set_idle();
    reset_n = 1'b0;
    #1;
    test_reset();
    test_cmp_beq();
    test_partial_write();
    test_failed_cond();
    test_cond_sweep();
    test_stall();
    test_reset_midseq();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/cond_logic.md
# cond_logic

Conditional-execution unit that consumes the 4-bit {N,Z,C,V} flags produced by the ALU. It holds the architectural flag register, evaluates the 4-bit ARM condition field of the current instruction against the stored flags, and gates the decoder's write-enable and branch signals. Flag updates from flag-setting instructions are committed on the clock edge. The block sits between the main decoder / ALU and the register file, data memory and PC mux.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset_n  in  1  synchronous, active-low reset
- Cond  in  4  instruction condition field, Instr[31:28]
- ALUFlags  in  4  {N,Z,C,V} from the ALU for the current instruction
- FlagW  in  2  flag-write request from the decoder; [1] = N,Z; [0] = C,V
- PCS  in  1  decoder: instruction writes the PC (branch or Rd = R15)
- RegW  in  1  decoder: instruction writes the register file
- MemW  in  1  decoder: instruction writes memory
- NoWrite  in  1  decoder: compare-type instruction (CMP/CMN/TST/TEQ); suppresses RegWrite
- Stall  in  1  freezes the flag register; the current instruction commits nothing
- PCSrc  out  1  gated PC-write enable
- RegWrite  out  1  gated register-file write enable
- MemWrite  out  1  gated memory write enable
- CondEx  out  1  condition passed
- Flags  out  4  current registered {N,Z,C,V}

## Operation
- Flag register: 4 bits, stored as {N,Z,C,V}.
- CondEx is a combinational decode of Cond against the registered Flags, never against ALUFlags:
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C & ~Z
  - 1001 LS: ~C | Z
  - 1010 GE: N == V
  - 1011 LT: N != V
  - 1100 GT: ~Z & (N == V)
  - 1101 LE: Z | (N != V)
  - 1110 AL: 1
  - 1111: 1 (treated as unconditional)
- Gated outputs:
  - PCSrc = PCS & CondEx & ~Stall
  - RegWrite = RegW & CondEx & ~NoWrite & ~Stall
  - MemWrite = MemW & CondEx & ~Stall
- While reset_n = 0: PCSrc, RegWrite and MemWrite are forced to 0 combinationally.
- Flag update at the rising edge of clk, in priority order:
  1. reset_n = 0: Flags <= 4'b0000.
  2. Stall = 1: hold.
  3. Otherwise, fields are updated independently:
     - Flags[3:2] <= ALUFlags[3:2] iff FlagW[1] & CondEx
     - Flags[1:0] <= ALUFlags[1:0] iff FlagW[0] & CondEx
- A failed condition suppresses the flag write as well as the other writes.
- FlagW = 2'b10 (logical ops with S) updates only N,Z; C,V hold their old value.

## Timing
- CondEx, PCSrc, RegWrite and MemWrite are purely combinational from Cond, the registered Flags and the enables. There is no added latency.
- A flag-setting instruction in cycle t affects CondEx from cycle t+1. The instruction itself is evaluated against the pre-update flags.
- Flags output is the register value, with no bypass.
- Reset values: Flags = 0000. With Flags = 0000, CondEx follows Cond (e.g. EQ = 0, NE = 1, AL = 1).
- Reset dominates Stall and FlagW in the same cycle.
- Reset asserted mid-sequence discards any pending flag write. Release takes effect at the first edge with reset_n = 1.
- Stall held for N cycles: Flags stay constant for all N edges, and all gated write outputs stay 0.

## Test plan
- Reset: hold reset_n = 0 for 2 cycles with FlagW = 11, ALUFlags = 1111, RegW = 1 -> Flags = 0000 after the edge; RegWrite = 0 throughout.
- CMP equal then BEQ:
  - Cycle 1: Cond = 1110, FlagW = 11, NoWrite = 1, RegW = 1, ALUFlags = 0110 -> RegWrite = 0; Flags = 0110 next cycle.
  - Cycle 2: Cond = 0000, PCS = 1 -> CondEx = 1, PCSrc = 1.
- Partial write: Flags = 0011, then FlagW = 10 with ALUFlags = 1000, Cond = AL -> Flags = 1011.
- Failed condition:
  - Flags = 0000; Cond = 0000 (EQ), FlagW = 11, ALUFlags = 0100, MemW = 1 -> CondEx = 0, MemWrite = 0; Flags stay 0000.
- Signed compares: for each of the 16 {N,Z,C,V} values, load the flags via FlagW = 11 with Cond = AL, then sweep all 16 Cond values -> CondEx matches the decode list (e.g. Flags = 1001 gives GE = 1, LT = 0, GT = 1).
- Stall:
  - Flags = 0100; Stall = 1 for 3 cycles with FlagW = 11, ALUFlags = 1010, RegW = 1, Cond = AL -> Flags = 0100, RegWrite = 0.
  - Release Stall -> Flags = 1010 one edge later.
